// File: rtl/lcd_frame_buffer.sv
// ----------------------------------------------------------------------------
// lcd_frame_buffer
//
// Double-buffered frame store for a two-chip page-organised monochrome LCD.
// Two 1024x8 banks: the front bank is streamed to the panel driver and the
// back bank is drawn into. A commit waits until the driver is between frames,
// swaps the banks, counts the swap and pulses start_o for two cycles so the
// driver begins a refresh on the falling edge of that pulse.
//
// Address layout (reads and writes): {chip[9], page[8:6], column[5:0]}.
// Data bit 0 is the top pixel of the page.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   wr_en_i      write strobe into the back bank (accepted only when idle)
//   wr_addr_i    write index
//   wr_data_i    write byte
//   clr_i        request fill of the back bank with CLEAR_VAL
//   commit_i     request front/back swap and panel refresh
//   rd_addr_i    read index from the panel driver
//   rd_data_o    front-bank byte at rd_addr_i, one cycle latency
//   drv_busy_i   driver is mid-frame; swap is held off while high
//   start_o      refresh trigger, high for exactly two cycles after a swap
//   busy_o       high whenever the controller is not idle
//   frame_cnt_o  number of completed swaps, wraps at 256
// ----------------------------------------------------------------------------
module lcd_frame_buffer #(
    parameter logic [7:0] CLEAR_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en_i,
    input  logic [9:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    input  logic       clr_i,
    input  logic       commit_i,
    input  logic [9:0] rd_addr_i,
    output logic [7:0] rd_data_o,
    input  logic       drv_busy_i,
    output logic       start_o,
    output logic       busy_o,
    output logic [7:0] frame_cnt_o
);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StWaitDrv,
        StStart
    } state_t;

    localparam logic [9:0] LastIdx = 10'd1023;

    state_t     state_q;
    logic       front_sel_q;   // 0: bank0 is front, 1: bank1 is front
    logic [9:0] clr_cnt_q;
    logic       start_hold_q;  // set after the first cycle of the start pulse

    logic [7:0] bank0_mem [1024];
    logic [7:0] bank1_mem [1024];

    logic       back_we;
    logic [9:0] back_addr;
    logic [7:0] back_data;

    // ------------------------------------------------------------------------
    // Back-bank write port: host writes while idle, fill pattern while clearing.
    // Gated by rst so an aborted clear stops on the reset edge.
    // ------------------------------------------------------------------------
    always_comb begin
        back_we   = 1'b0;
        back_addr = wr_addr_i;
        back_data = wr_data_i;
        if (!rst) begin
            if (state_q == StClear) begin
                back_we   = 1'b1;
                back_addr = clr_cnt_q;
                back_data = CLEAR_VAL;
            end else if (state_q == StIdle && wr_en_i) begin
                back_we   = 1'b1;
            end
        end
    end

    // Bank contents are deliberately not reset; software clears before use.
    // Each bank is written only while it is the back bank, so a read and a
    // write to the same index in one cycle never touch the same storage.
    always_ff @(posedge clk) begin
        if (back_we && front_sel_q) begin
            bank0_mem[back_addr] <= back_data;
        end
    end

    always_ff @(posedge clk) begin
        if (back_we && !front_sel_q) begin
            bank1_mem[back_addr] <= back_data;
        end
    end

    // Front-bank read. Uses the registered front_sel_q, so on the swap edge
    // the old front bank is still the one sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_o <= 8'h00;
        end else if (front_sel_q) begin
            rd_data_o <= bank1_mem[rd_addr_i];
        end else begin
            rd_data_o <= bank0_mem[rd_addr_i];
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            front_sel_q  <= 1'b0;
            clr_cnt_q    <= 10'd0;
            frame_cnt_o  <= 8'd0;
            start_o      <= 1'b0;
            start_hold_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Clear wins over a simultaneous commit; the commit is lost.
                    if (clr_i) begin
                        state_q   <= StClear;
                        clr_cnt_q <= 10'd0;
                    end else if (commit_i) begin
                        state_q <= StWaitDrv;
                    end
                end
                StClear: begin
                    // Counter wraps to zero on the final increment.
                    clr_cnt_q <= clr_cnt_q + 10'd1;
                    if (clr_cnt_q == LastIdx) begin
                        state_q <= StIdle;
                    end
                end
                StWaitDrv: begin
                    if (!drv_busy_i) begin
                        front_sel_q  <= ~front_sel_q;
                        frame_cnt_o  <= frame_cnt_o + 8'd1;
                        start_o      <= 1'b1;
                        start_hold_q <= 1'b0;
                        state_q      <= StStart;
                    end
                end
                StStart: begin
                    if (start_hold_q) begin
                        start_o <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        start_hold_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Decoded from registered state only.
    assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_lcd_frame_buffer.sv
// ----------------------------------------------------------------------------
// tb_lcd_frame_buffer
//
// Directed bench. Reads are scoreboarded: each issued read pushes its expected
// byte, and a monitor pops and compares on the cycle rd_data_o is presented.
// Control outputs are compared directly with hand-computed values.
// ----------------------------------------------------------------------------
module tb_lcd_frame_buffer;

    localparam logic [7:0] CV = 8'h5A;

    logic       clk;
    logic       rst;
    logic       wr_en_i;
    logic [9:0] wr_addr_i;
    logic [7:0] wr_data_i;
    logic       clr_i;
    logic       commit_i;
    logic [9:0] rd_addr_i;
    logic [7:0] rd_data_o;
    logic       drv_busy_i;
    logic       start_o;
    logic       busy_o;
    logic [7:0] frame_cnt_o;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;
    logic       rd_pend = 1'b0;
    logic       rd_chk  = 1'b0;

    lcd_frame_buffer #(
        .CLEAR_VAL(CV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .clr_i      (clr_i),
        .commit_i   (commit_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .drv_busy_i (drv_busy_i),
        .start_o    (start_o),
        .busy_o     (busy_o),
        .frame_cnt_o(frame_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: a read issued before edge N is presented after edge N.
    always @(posedge clk) rd_chk <= rd_pend;

    always @(negedge clk) begin
        if (rd_chk) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data: no expectation queued, got %02h", rd_data_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rd_data_o !== mon_exp) begin
                    errors++;
                    $display("FAIL rd_data: got %02h expected %02h (t=%0t)",
                             rd_data_o, mon_exp, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic read_exp(input logic [9:0] a, input logic [7:0] e);
        rd_addr_i = a;
        exp_q.push_back(e);
        rd_pend = 1'b1;
        tick();
    endtask

    task automatic rd_done();
        rd_pend = 1'b0;
        tick();
        tick();
    endtask

    task automatic write_byte(input logic [9:0] a, input logic [7:0] d);
        wr_en_i   = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        tick();
        wr_en_i   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Pulse clr_i (optionally with commit_i) and measure busy length. With
    // inject set, attempt a write to index 5 well after it has been cleared.
    task automatic do_clear(input bit with_commit, input bit inject);
        int cnt = 0;
        int sh  = 0;
        clr_i    = 1'b1;
        commit_i = with_commit;
        tick();
        clr_i    = 1'b0;
        commit_i = 1'b0;
        while (busy_o === 1'b1 && cnt < 2000) begin
            cnt++;
            if (start_o) sh++;
            if (inject && cnt == 600) begin
                wr_en_i   = 1'b1;
                wr_addr_i = 10'h005;
                wr_data_i = 8'hFF;
            end else begin
                wr_en_i = 1'b0;
            end
            tick();
        end
        wr_en_i = 1'b0;
        chk("clear_busy_cycles", cnt, 1024);
        chk("clear_no_start", sh, 0);
    endtask

    // Commit with driver idle; measure start pulse width and the new count.
    task automatic do_commit(input logic [7:0] exp_frame);
        int n = 0;
        int h = 0;
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        while (start_o !== 1'b1 && n < 100) begin
            n++;
            tick();
        end
        while (start_o === 1'b1 && h < 10) begin
            h++;
            tick();
        end
        chk("start_cycles", h, 2);
        chk("frame_cnt", frame_cnt_o, exp_frame);
        chk("busy_after_commit", busy_o, 0);
    endtask

    initial begin
        rst        = 1'b0;
        wr_en_i    = 1'b0;
        wr_addr_i  = '0;
        wr_data_i  = '0;
        clr_i      = 1'b0;
        commit_i   = 1'b0;
        rd_addr_i  = '0;
        drv_busy_i = 1'b0;

        // Reset state
        do_reset();
        chk("rst_busy", busy_o, 0);
        chk("rst_start", start_o, 0);
        chk("rst_frame", frame_cnt_o, 0);
        chk("rst_rd_data", rd_data_o, 8'h00);

        // Clear, commit, sweep the whole new front bank
        do_clear(1'b0, 1'b0);
        do_commit(8'd1);
        for (int a = 0; a < 1024; a++) begin
            read_exp(10'(a), CV);
        end
        rd_done();

        // Corner writes after reset (back = cleared bank1)
        do_reset();
        write_byte(10'h3FF, 8'hA5);
        write_byte(10'h000, 8'h3C);
        do_commit(8'd1);
        read_exp(10'h3FF, 8'hA5);
        read_exp(10'h000, 8'h3C);
        read_exp(10'h001, CV);
        rd_done();

        // Prepare bank0; same-index read and write hit different banks
        do_clear(1'b0, 1'b0);
        wr_en_i   = 1'b1;
        wr_addr_i = 10'h3FF;
        wr_data_i = 8'h77;
        read_exp(10'h3FF, 8'hA5);
        wr_en_i   = 1'b0;
        rd_done();

        // Commit held off by busy driver; writes during the wait are dropped
        drv_busy_i = 1'b1;
        commit_i   = 1'b1;
        tick();
        commit_i   = 1'b0;
        for (int i = 0; i < 50; i++) begin
            wr_en_i   = (i == 10);
            wr_addr_i = 10'h3FF;
            wr_data_i = 8'h11;
            rd_addr_i = 10'h3FF;
            exp_q.push_back(8'hA5);
            rd_pend   = 1'b1;
            tick();
            chk("wait_start_low", start_o, 0);
        end
        wr_en_i = 1'b0;
        chk("wait_frame", frame_cnt_o, 1);
        chk("wait_busy", busy_o, 1);
        drv_busy_i = 1'b0;
        read_exp(10'h3FF, 8'hA5);   // swap edge still reads the old front
        chk("swap_start", start_o, 1);
        chk("swap_frame", frame_cnt_o, 2);
        read_exp(10'h3FF, 8'h77);
        chk("swap_start_2nd", start_o, 1);
        rd_done();
        chk("swap_idle", busy_o, 0);

        // Clear with simultaneous commit; write injected mid-clear
        do_clear(1'b1, 1'b1);
        chk("clr_commit_frame", frame_cnt_o, 2);
        do_commit(8'd3);
        read_exp(10'h005, CV);
        read_exp(10'h3FF, CV);
        read_exp(10'h000, CV);
        rd_done();

        // Frame counter wrap
        for (int k = 1; k <= 256; k++) begin
            do_commit(8'(3 + k));
            if (k == 253) chk("frame_wrap_zero", frame_cnt_o, 0);
        end
        chk("frame_wrap_full", frame_cnt_o, 3);

        // Reset on the 500th clear cycle
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        for (int i = 0; i < 499; i++) tick();
        chk("mid_clear_busy", busy_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_clear_busy", busy_o, 0);
        chk("abort_clear_frame", frame_cnt_o, 0);
        chk("abort_clear_rd", rd_data_o, 8'h00);

        // Reset during the start pulse
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        tick();
        chk("pre_abort_start", start_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_start_start", start_o, 0);
        chk("abort_start_frame", frame_cnt_o, 0);
        chk("abort_start_busy", busy_o, 0);

        tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_frame_buffer.md
LCD_FRAME_BUFFER -- requirements
Module: lcd_frame_buffer

Interface
REQ-001 SHALL have parameter CLEAR_VAL, default 8'h00: byte written to every back-buffer location by a clear.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port wr_en_i  input  1  write strobe into back buffer.
REQ-005 SHALL have port wr_addr_i  input  10  write index {chip[9], page[8:6], column[5:0]}.
REQ-006 SHALL have port wr_data_i  input  8  write byte (bit0 = top pixel of page).
REQ-007 SHALL have port clr_i  input  1  request clear of back buffer.
REQ-008 SHALL have port commit_i  input  1  request front/back swap and panel refresh.
REQ-009 SHALL have port rd_addr_i  input  10  read index from panel driver, same layout as wr_addr_i.
REQ-010 SHALL have port rd_data_o  output  8  front-buffer byte at rd_addr_i.
REQ-011 SHALL have port drv_busy_i  input  1  panel driver mid-frame; swap forbidden while high.
REQ-012 SHALL have port start_o  output  1  refresh trigger to driver; driver acts on its falling edge.
REQ-013 SHALL have port busy_o  output  1  high whenever FSM not IDLE.
REQ-014 SHALL have port frame_cnt_o  output  8  count of completed swaps.

Function
REQ-015 SHALL hold two 1024x8 banks; register front_sel selects front bank, the other is back.
REQ-016 SHALL register rd_data_o <= front[rd_addr_i] every cycle: 1-cycle latency, no enable.
REQ-017 SHALL write wr_data_i to back[wr_addr_i] only when wr_en_i=1 and state=IDLE; writes in other states silently dropped.
REQ-018 SHALL never let writes or clears touch the front bank; same-address read/write in one cycle hits different banks, no hazard.
REQ-019 SHALL implement FSM states IDLE, CLEAR, WAIT_DRV, START.
REQ-020 IDLE: clr_i=1 -> CLEAR with clr_cnt=0; else commit_i=1 -> WAIT_DRV; clr_i has priority, simultaneous commit_i discarded.
REQ-021 CLEAR: each cycle write CLEAR_VAL to back[clr_cnt], clr_cnt+1; after writing index 1023 (exactly 1024 cycles) -> IDLE; clr_i, commit_i ignored.
REQ-022 WAIT_DRV: while drv_busy_i=1 hold; first cycle drv_busy_i=0 -> toggle front_sel, frame_cnt_o+1 (8-bit wrap 255->0), start_o<=1, -> START.
REQ-023 START: start_o stays high for exactly 2 cycles total, then start_o<=0 and -> IDLE in the same edge.
REQ-024 rd_data_o in the swap cycle uses old front_sel; first read of the new front bank appears on the cycle after the toggle edge.
REQ-025 busy_o SHALL be decoded from registered state only (no input-to-output combinational path).
REQ-026 clr_cnt SHALL be 10 bits, no overflow past 1023.
REQ-027 commit_i pulses while busy_o=1 SHALL be dropped, not queued.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, front_sel=0, clr_cnt=0, frame_cnt_o=0, start_o=0, busy_o=0, rd_data_o=8'h00.
REQ-029 Bank contents SHALL NOT be reset; software issues clr_i before first commit.
REQ-030 rst asserted mid-CLEAR or mid-START SHALL abort immediately to REQ-028 values; start_o falls on that edge.

Verification
REQ-031 rst, clr_i 1 cycle -> busy_o high exactly 1024 cycles; commit, drv_busy_i=0 -> every rd_addr 0..1023 returns 8'h00 one cycle later.
REQ-032 Write 8'hA5 @10'h3FF, 8'h3C @10'h000, commit -> start_o high 2 cycles, frame_cnt_o=1, rd_addr 3FF->A5, 000->3C.
REQ-033 commit_i with drv_busy_i=1 for 50 cycles -> front_sel, start_o unchanged 50 cycles; drop drv_busy_i -> swap next edge.
REQ-034 clr_i and commit_i same cycle -> CLEAR only, no start_o pulse, frame_cnt_o unchanged.
REQ-035 wr_en_i during CLEAR @10'h005 data 8'hFF -> after clear back[5]=CLEAR_VAL; 256 commits -> frame_cnt_o wraps to 0.
REQ-036 rst asserted on 500th CLEAR cycle -> next cycle busy_o=0, frame_cnt_o=0, rd_data_o=8'h00.
